// File: rtl/booth_r4_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_r4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One recoded Booth digit: value = zero ? 0 : (neg ? -1 : +1) * (two ? 2M : M)
    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } booth_digit_t;

    // Extended operand width: WIDTH+1 rounded up to even, so that an unsigned
    // operand gets a zero sign bit and the digit count comes out whole.
    function automatic int ew_f(input int width);
        return ((width + 2) / 2) * 2;
    endfunction

    // Number of radix-4 digits, one per CALC cycle.
    function automatic int iter_f(input int width);
        return ew_f(width) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: overlapping multiplier triplet -> signed digit.
module booth_r4_enc
    import booth_r4_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    // Standard Booth table; 000 and 111 both recode to zero.
    always_comb begin
        digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
        unique case (triplet)
            3'b000: digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
            3'b001: digit = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
            3'b010: digit = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
            3'b011: digit = '{zero: 1'b0, neg: 1'b0, two: 1'b1};
            3'b100: digit = '{zero: 1'b0, neg: 1'b1, two: 1'b1};
            3'b101: digit = '{zero: 1'b0, neg: 1'b1, two: 1'b0};
            3'b110: digit = '{zero: 1'b0, neg: 1'b1, two: 1'b0};
            3'b111: digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
            default: digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
        endcase
    end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned
// per operation, valid/ready on both sides, synchronous abort.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | retiring one Booth digit per cycle
// DONE  | product held with out_valid until consumed or aborted
//
// Optional build macro BOOTH_R4_MUL_ACC_EN adds an 'acc' input: when set with
// the operands, the result becomes last_delivered_product + a*b (mod 2^(2*WIDTH)).
module booth_r4_mul_seq
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
`ifdef BOOTH_R4_MUL_ACC_EN
    input  logic               acc,
`endif
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int EW   = ew_f(WIDTH);
    localparam int ITER = iter_f(WIDTH);
    localparam int AW   = 2 * EW + 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_t             state, state_nxt;
    logic [EW-1:0]      ext_a, ext_b;
    logic [EW-1:0]      m_q;
    logic [EW:0]        mreg;
    logic [AW-1:0]      acc_q, acc_nxt;
    logic [CW-1:0]      cnt;
    logic               last_digit;
    booth_digit_t       digit;

    logic [EW+1:0]      m_wide, mag, term, sum_hi;
    logic [AW-1:0]      shifted;

`ifdef BOOTH_R4_MUL_ACC_EN
    logic               tc_q;
    logic               add_prev_q;
    logic [PW-1:0]      prev_q;
    logic [AW-1:0]      base_ext;
`endif

    assign ext_a      = {{(EW-WIDTH){tc & a[WIDTH-1]}}, a};
    assign ext_b      = {{(EW-WIDTH){tc & b[WIDTH-1]}}, b};
    assign last_digit = (cnt == CW'(ITER - 1));
    assign product    = acc_q[PW-1:0];

    booth_r4_enc u_enc (
        .triplet (mreg[2:0]),
        .digit   (digit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort wins over out_ready
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: begin
                if (abort)           state_nxt = IDLE;
                else if (last_digit) state_nxt = DONE;
            end
            DONE: begin
                if (abort)          state_nxt = IDLE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

`ifdef BOOTH_R4_MUL_ACC_EN
    // Previous product enters on the final digit rather than at load time:
    // anything placed in the accumulator up front would be shifted out.
    assign base_ext = add_prev_q ? {{(AW-PW){tc_q & prev_q[PW-1]}}, prev_q} : '0;
`endif

    // One digit step: add the selected multiple into the upper half, then shift right by 2
    always_comb begin
        m_wide  = {{2{m_q[EW-1]}}, m_q};
        mag     = digit.two ? {m_wide[EW:0], 1'b0} : m_wide;
        term    = digit.zero ? '0 : (digit.neg ? (~mag + (EW+2)'(1)) : mag);
        sum_hi  = acc_q[AW-1:EW] + term;
        shifted = {{2{sum_hi[EW+1]}}, sum_hi, acc_q[EW-1:2]};
        acc_nxt = shifted;
`ifdef BOOTH_R4_MUL_ACC_EN
        if (last_digit) acc_nxt = shifted + base_ext;
`endif
    end

    // Operand capture at the input handshake and per-digit datapath update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            mreg  <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            m_q   <= ext_a;
            mreg  <= {ext_b, 1'b0};
            acc_q <= '0;
            cnt   <= '0;
        end else if (state == CALC && !abort) begin
            acc_q <= acc_nxt;
            mreg  <= {2'b00, mreg[EW:2]};
            cnt   <= cnt + 1'b1;
        end
    end

`ifdef BOOTH_R4_MUL_ACC_EN
    // Accumulate-mode bookkeeping: mode bits per operation, last delivered product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q       <= 1'b0;
            add_prev_q <= 1'b0;
            prev_q     <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                tc_q       <= tc;
                add_prev_q <= acc;
            end
            if (state == DONE && out_ready && !abort)
                prev_q <= acc_q[PW-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Directed self-checking bench for booth_r4_mul_seq at WIDTH=8 (EW=10, ITER=5).
module tb_booth_r4_mul_seq;

    localparam int W   = 8;
    localparam int LAT = 5;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         tc;
`ifdef BOOTH_R4_MUL_ACC_EN
    logic         acc_in;
`endif
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] product;
    logic         busy;

    int tests;
    int fails;

    booth_r4_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tc        (tc),
`ifdef BOOTH_R4_MUL_ACC_EN
        .acc       (acc_in),
`endif
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operation at a falling edge, let it be taken on the next rising
    // edge, then scramble the operand inputs to show they are not re-sampled.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic tcv, input logic accv);
        @(negedge clk);
        a = av; b = bv; tc = tcv; in_valid = 1'b1;
`ifdef BOOTH_R4_MUL_ACC_EN
        acc_in = accv;
`else
        if (accv) $display("[TB] acc requested but feature not built");
`endif
        check("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = bv ^ 8'h5A; tc = ~tcv;
`ifdef BOOTH_R4_MUL_ACC_EN
        acc_in = ~accv;
`endif
    endtask

    // Count falling edges until out_valid; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_within_bound", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic tcv, input logic accv, input logic [2*W-1:0] exp);
        int lat;
        accept(av, bv, tcv, accv);
        wait_done(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        logic seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
`ifdef BOOTH_R4_MUL_ACC_EN
        acc_in = 1'b0;
`endif
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_product",   {16'd0, product},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // -128 * -128 signed: largest magnitude corner
        run_op("neg128_sq", 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);
        // same bit patterns, both modes
        run_op("ff_ff_uns", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
        run_op("ff_ff_sgn", 8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001);
        run_op("uns_mixed", 8'h80, 8'h03, 1'b0, 1'b0, 16'h0180);
        run_op("sgn_mixed", 8'h80, 8'h03, 1'b1, 1'b0, 16'hFE80);

        // -1 * 1 with output back-pressure
        accept(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_done(lat);
        check("hold_latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            check("hold_product",   {16'd0, product},   32'h0000FFFF);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        consume();

        // abort in the 3rd CALC cycle
        accept(8'd3, 8'd5, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_busy",      {31'd0, busy},      32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | out_valid;
            @(negedge clk);
        end
        check("abort_no_out_valid", {31'd0, seen}, 32'd0);
        run_op("after_abort", 8'd2, 8'd7, 1'b1, 1'b0, 16'h000E);

        // abort in DONE together with out_ready: abort wins, nothing delivered
        accept(8'd5, 8'd5, 1'b1, 1'b0);
        wait_done(lat);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_done_in_ready",  {31'd0, in_ready},  32'd1);

        // asynchronous reset mid-CALC
        accept(8'd9, 8'd9, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy},      32'd0);
        check("arst_product",   {16'd0, product},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("zero_x_neg", 8'h00, 8'h80, 1'b1, 1'b0, 16'h0000);

`ifdef BOOTH_R4_MUL_ACC_EN
        run_op("acc_op1", 8'd10, 8'd10, 1'b1, 1'b0, 16'd100);
        // aborted in DONE: must not replace the remembered product
        accept(8'd5, 8'd5, 1'b1, 1'b0);
        wait_done(lat);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run_op("acc_op2", 8'hFD, 8'd4, 1'b1, 1'b1, 16'h0058);
        run_op("acc_op3", 8'd1, 8'd1, 1'b1, 1'b0, 16'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
